// File: rtl/grid_readout.sv
// Snapshots a GRIDSIZE x GRIDSIZE cell grid on start and streams it row-major over a valid/ready beat port.
// Optional population counting is enabled by defining GRID_READOUT_POPCOUNT_EN.
module grid_readout #(
  parameter int unsigned GRIDSIZE = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [GRIDSIZE*GRIDSIZE-1:0]             cells,
  input  logic                                     start,
  input  logic                                     out_ready,
  output logic                                     out_valid,
  output logic                                     out_bit,
  output logic                                     out_sof,
  output logic                                     out_eol,
  output logic                                     busy,
  output logic [$clog2(GRIDSIZE*GRIDSIZE+1)-1:0]   population,
  output logic                                     pop_valid
);

  localparam int unsigned NCELL = GRIDSIZE * GRIDSIZE;
  localparam int unsigned CW    = $clog2(GRIDSIZE);
  localparam int unsigned IW    = $clog2(NCELL);
  localparam int unsigned PW    = $clog2(NCELL + 1);
  localparam logic [CW-1:0] LAST = CW'(GRIDSIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [NCELL-1:0]  snap_q, snap_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [PW-1:0]     pop_q, pop_d;
  logic [IW-1:0]     idx_d;
  logic              xfer;
  logic              stream_d;
  logic              out_bit_d;
  logic              out_sof_d;
  logic              out_eol_d;
  logic              pop_valid_d;

  assign xfer       = out_valid & out_ready;
  assign population = pop_q;

  // Next-state, counter and next-output logic; outputs are registered from the next values
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    row_d       = row_q;
    col_d       = col_q;
    pop_d       = pop_q;
    pop_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = cells;
          row_d   = '0;
          col_d   = '0;
          pop_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
`ifdef GRID_READOUT_POPCOUNT_EN
          if (out_bit) pop_d = pop_q + PW'(1);
`endif
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) state_d = DONE;
            else               row_d   = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifndef GRID_READOUT_POPCOUNT_EN
    pop_d = '0;
`else
    pop_valid_d = (state_d == DONE);
`endif

    stream_d  = (state_d == STREAM);
    idx_d     = IW'(row_d) * IW'(GRIDSIZE) + IW'(col_d);
    out_bit_d = stream_d & snap_d[idx_d];
    out_sof_d = stream_d & (row_d == '0) & (col_d == '0);
    out_eol_d = stream_d & (col_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pop_q     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      busy      <= 1'b0;
      pop_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pop_q     <= pop_d;
      out_valid <= stream_d;
      out_bit   <= out_bit_d;
      out_sof   <= out_sof_d;
      out_eol   <= out_eol_d;
      busy      <= (state_d != IDLE);
      pop_valid <= pop_valid_d;
    end
  end

endmodule

// File: doc/grid_readout.md
GRID_READOUT -- requirements
Module: grid_readout

Interface
REQ-001 The module SHALL have parameter GRIDSIZE, default 3, meaning the grid edge length in cells; legal range is 2..64.
REQ-002 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, meaning reset; it is asynchronous and active-high.
REQ-004 The module SHALL have port cells, input, GRIDSIZE*GRIDSIZE bits, meaning the flattened live grid, with cell (row i, col j) at bit i*GRIDSIZE+j and 1 meaning alive.
REQ-005 The module SHALL have port start, input, 1 bit, meaning a request to snapshot and stream the grid.
REQ-006 The module SHALL have port out_ready, input, 1 bit, meaning the sink accepts the current beat.
REQ-007 The module SHALL have port out_valid, output, 1 bit, meaning out_bit, out_sof and out_eol are valid.
REQ-008 The module SHALL have port out_bit, output, 1 bit, meaning the state of the current cell.
REQ-009 The module SHALL have port out_sof, output, 1 bit, meaning the current beat is cell (0,0).
REQ-010 The module SHALL have port out_eol, output, 1 bit, meaning the current beat is the last column of a row.
REQ-011 The module SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE.
REQ-012 The module SHALL have port population, output, $clog2(GRIDSIZE*GRIDSIZE+1) bits, meaning the count of alive cells in the last snapshot.
REQ-013 The module SHALL have port pop_valid, output, 1 bit, meaning a one-cycle strobe that population is final.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, STREAM and DONE.
REQ-015 In IDLE, start=1 at a clock edge SHALL register the snapshot of cells, clear row/col counters and population, and move to STREAM; out_valid rises on the next cycle.
REQ-016 start SHALL be ignored in STREAM and DONE, and the snapshot SHALL NOT change until the next accepted start.
REQ-017 In STREAM, out_valid SHALL be 1 and out_bit SHALL equal snapshot bit row*GRIDSIZE+col, streamed in row-major order starting at (0,0).
REQ-018 A beat SHALL transfer only on an edge with out_valid=1 and out_ready=1; without a transfer, all out_* outputs SHALL hold stable.
REQ-019 On a transfer, col SHALL increment; at col=GRIDSIZE-1 it SHALL wrap to 0 and row SHALL increment.
REQ-020 out_sof SHALL be 1 only when row=0 and col=0; out_eol SHALL be 1 only when col=GRIDSIZE-1; both SHALL be 0 when out_valid=0.
REQ-021 On the transfer of cell (GRIDSIZE-1, GRIDSIZE-1), the FSM SHALL move to DONE and out_valid SHALL drop on the next cycle.
REQ-022 DONE SHALL last exactly one cycle with pop_valid=1, then return to IDLE.
REQ-023 The minimum start-to-start period with out_ready held at 1 SHALL be GRIDSIZE*GRIDSIZE+2 cycles.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE and out_valid, out_bit, out_sof, out_eol, busy, pop_valid, population, the snapshot and the counters SHALL all be 0.
REQ-025 Reset asserted mid-STREAM or in DONE SHALL abort immediately with no further beats and no pop_valid pulse.
REQ-026 After rst deasserts, the first accepted start SHALL behave exactly as REQ-015.

Configuration
REQ-027 Macro GRID_READOUT_POPCOUNT_EN SHALL control population counting; when defined, population SHALL increment by 1 on each transferred beat with out_bit=1 and SHALL hold its final value from DONE until the next accepted start.
REQ-028 When GRID_READOUT_POPCOUNT_EN is undefined, population SHALL be constant 0 and pop_valid SHALL never assert; the FSM and stream SHALL be unchanged.

Verification
REQ-029 Scenario 1: GRIDSIZE=3, cells=9'b000111000, out_ready=1, start pulse -> out_bit sequence 0,0,0,1,1,1,0,0,0; out_sof on beat 0; out_eol on beats 2, 5 and 8; pop_valid with population=3.
REQ-030 Scenario 2: same as Scenario 1, but out_ready toggles 1,0,1,0,... -> the same 9-beat sequence is produced and outputs are stable in every stalled cycle.
REQ-031 Scenario 3: start held at 1 throughout, and cells changed to 9'h1FF mid-stream -> only the original snapshot is streamed, and the next stream begins 11 cycles after the first start with population=9.
REQ-032 Scenario 4: rst pulsed after 4 beats -> out_valid=0 and population=0 while rst=1, and no pop_valid pulse; a new start then streams from (0,0).
REQ-033 Scenario 5: GRID_READOUT_POPCOUNT_EN undefined and cells=9'h1FF -> 9 beats all 1, population stays 0, and pop_valid is never asserted.
